// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//   Parametrised MIPS general-purpose register file with a hardwired-zero
//   register 0 (ZERO_REG), a per-register pending scoreboard for hazard
//   detection and a runtime clear sequencer that zeroes the whole array
//   over DEPTH cycles without a chip reset.
//
//   Optional feature: define REGFILE_BYPASS_EN for write-first forwarding
//   (a same-cycle write is visible on a matching read port). Without it the
//   read ports are read-before-write.
//
// Parameters
//   DATA_WIDTH   register width
//   ADDR_WIDTH   address width, DEPTH = 2**ADDR_WIDTH
//   ZERO_REG     1: register 0 reads 0 and ignores writes and reserves
//
// Ports
//   Clk, Rst_n                    clock, async active-low reset
//   ReadRegister1/2 -> ReadData1/2 combinational read ports
//   WriteRegister, WriteData, RegWrite   writeback port
//   Reserve, ReserveReg           mark a register pending (producer issued)
//   Pending1/2                    scoreboard bit for ReadRegister1/2
//   ClearReq                      start the zeroing sweep (ignored when busy)
//   Busy                          sweep in progress
// -----------------------------------------------------------------------------
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  Reserve,
    input  logic [ADDR_WIDTH-1:0] ReserveReg,
    output logic                  Pending1,
    output logic                  Pending2,
    input  logic                  ClearReq,
    output logic                  Busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] sweepCnt;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pend;

    logic writeEn;
    logic reserveEn;

    // Writes and reserves are only honoured while idle; register 0 is
    // filtered here so neither the array nor the scoreboard ever holds it.
    assign writeEn   = RegWrite && (state == IDLE) &&
                       !((ZERO_REG != 0) && (WriteRegister == '0));
    assign reserveEn = Reserve && (state == IDLE) &&
                       !((ZERO_REG != 0) && (ReserveReg == '0));

    assign Busy = (state == SWEEP);

    // NOTE: the array is reset like any other state because reset must
    // leave every register reading 0; this rules out a RAM macro here.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regs     <= '{default: '0};
            pend     <= '0;
            state    <= IDLE;
            sweepCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (writeEn) begin
                        regs[WriteRegister] <= WriteData;
                        pend[WriteRegister] <= 1'b0;
                    end
                    // NOTE: non-blocking updates resolve last-wins, so this
                    // set placed after the clear gives reserve priority on a
                    // same-register collision.
                    if (reserveEn) begin
                        pend[ReserveReg] <= 1'b1;
                    end
                    if (ClearReq) begin
                        state <= SWEEP;
                    end
                end
                SWEEP: begin
                    regs[sweepCnt] <= '0;
                    pend[sweepCnt] <= 1'b0;
                    sweepCnt       <= sweepCnt + 1'b1;  // wraps to 0 at the end
                    if (&sweepCnt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output is given its default first, so no path through
    // these blocks leaves one unassigned and no latch is inferred.
    always_comb begin
        ReadData1 = regs[ReadRegister1];
        Pending1  = pend[ReadRegister1];
`ifdef REGFILE_BYPASS_EN
        if (writeEn && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
            Pending1  = 1'b0;
        end
`endif
        if ((ZERO_REG != 0) && (ReadRegister1 == '0)) begin
            ReadData1 = '0;
            Pending1  = 1'b0;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        Pending2  = pend[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (writeEn && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
            Pending2  = 1'b0;
        end
`endif
        if ((ZERO_REG != 0) && (ReadRegister2 == '0)) begin
            ReadData2 = '0;
            Pending2  = 1'b0;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// -----------------------------------------------------------------------------
// tb_param_register_file
//   Scoreboard bench for param_register_file (32 x 32, ZERO_REG = 1).
//   Stimulus drives inputs just after a posedge and queues the values the
//   outputs must show in that cycle; a monitor samples on the following
//   negedge and compares every queued entry.
// -----------------------------------------------------------------------------
module tb_param_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam int SEL_RD1  = 0;
    localparam int SEL_RD2  = 1;
    localparam int SEL_P1   = 2;
    localparam int SEL_P2   = 3;
    localparam int SEL_BUSY = 4;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string         name;
        int            sel;
        logic [DW-1:0] value;
    } expect_t;

    logic          Clk;
    logic          Rst_n;
    logic [AW-1:0] ReadRegister1, ReadRegister2;
    logic [DW-1:0] ReadData1, ReadData2;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic          Reserve;
    logic [AW-1:0] ReserveReg;
    logic          Pending1, Pending2;
    logic          ClearReq;
    logic          Busy;

    expect_t scoreboard [$];
    int      checkCount = 0;
    int      errorCount = 0;

    param_register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ZERO_REG  (1)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RegWrite     (RegWrite),
        .Reserve      (Reserve),
        .ReserveReg   (ReserveReg),
        .Pending1     (Pending1),
        .Pending2     (Pending2),
        .ClearReq     (ClearReq),
        .Busy         (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [DW-1:0] actual,
                         input logic [DW-1:0] required);
        checkCount++;
        if (actual !== required) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    task automatic expectOut(input string name, input int sel, input logic [DW-1:0] value);
        expect_t e;
        e.name  = name;
        e.sel   = sel;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge Clk) begin
        while (scoreboard.size() > 0) begin
            expect_t e;
            logic [DW-1:0] actual;
            e = scoreboard.pop_front();
            case (e.sel)
                SEL_RD1: actual = ReadData1;
                SEL_RD2: actual = ReadData2;
                SEL_P1:  actual = {{(DW-1){1'b0}}, Pending1};
                SEL_P2:  actual = {{(DW-1){1'b0}}, Pending2};
                default: actual = {{(DW-1){1'b0}}, Busy};
            endcase
            check(e.name, actual, e.value);
        end
    end

    initial begin
        Rst_n         = 1'b0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        WriteRegister = '0;
        WriteData     = '0;
        RegWrite      = 1'b0;
        Reserve       = 1'b0;
        ReserveReg    = '0;
        ClearReq      = 1'b0;
        repeat (2) tick();
        Rst_n = 1'b1;

        // Reset state: every address reads 0 and nothing is pending.
        expectOut("reset_busy", SEL_BUSY, 0);
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = AW'(a);
            ReadRegister2 = AW'(31 - a);
            expectOut("reset_rd1", SEL_RD1, 0);
            expectOut("reset_rd2", SEL_RD2, 0);
            expectOut("reset_p1", SEL_P1, 0);
            expectOut("reset_p2", SEL_P2, 0);
            tick();
        end

        // Basic write then read.
        RegWrite = 1'b1; WriteRegister = 5; WriteData = 32'hDEADBEEF; ReadRegister1 = 1;
        tick();
        RegWrite = 1'b0; ReadRegister1 = 5;
        expectOut("wr5_rd", SEL_RD1, 32'hDEADBEEF);
        tick();

        // Register 0 ignores writes and reserves.
        RegWrite = 1'b1; WriteRegister = 0; WriteData = 32'h12345678;
        Reserve = 1'b1; ReserveReg = 0; ReadRegister1 = 0;
        expectOut("r0_same_rd", SEL_RD1, 0);
        expectOut("r0_same_p", SEL_P1, 0);
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        expectOut("r0_rd", SEL_RD1, 0);
        expectOut("r0_p", SEL_P1, 0);
        tick();

        // Same-cycle write and read of reg 7.
        RegWrite = 1'b1; WriteRegister = 7; WriteData = 32'hA5A5A5A5; ReadRegister1 = 7;
        expectOut("fwd_same", SEL_RD1, BYPASS ? 32'hA5A5A5A5 : 32'h0);
        tick();
        RegWrite = 1'b0;
        expectOut("fwd_next", SEL_RD1, 32'hA5A5A5A5);
        tick();

        // Scoreboard on reg 9.
        Reserve = 1'b1; ReserveReg = 9; ReadRegister2 = 9;
        expectOut("rsv9_same", SEL_P2, 0);
        tick();
        Reserve = 1'b0;
        expectOut("rsv9_next", SEL_P2, 1);
        tick();
        Reserve = 1'b1; ReserveReg = 9;
        RegWrite = 1'b1; WriteRegister = 9; WriteData = 32'h99;
        expectOut("rsv_wr9_same_p", SEL_P2, BYPASS ? 0 : 1);
        tick();
        Reserve = 1'b0; RegWrite = 1'b0;
        expectOut("rsv_wr9_set_wins", SEL_P2, 1);
        expectOut("rsv_wr9_data", SEL_RD2, 32'h99);
        tick();
        RegWrite = 1'b1; WriteRegister = 9; WriteData = 32'h100;
        expectOut("wr9_same_p", SEL_P2, BYPASS ? 0 : 1);
        tick();
        RegWrite = 1'b0;
        expectOut("wr9_clears", SEL_P2, 0);
        expectOut("wr9_data", SEL_RD2, 32'h100);
        tick();

        // Fill regs 1..31 with ones and leave reg 12 pending.
        for (int a = 1; a < 32; a++) begin
            RegWrite = 1'b1; WriteRegister = AW'(a); WriteData = 32'hFFFFFFFF;
            tick();
        end
        RegWrite = 1'b0;
        Reserve = 1'b1; ReserveReg = 12;
        tick();
        Reserve = 1'b0; ReadRegister1 = 12; ReadRegister2 = 31;
        expectOut("pre_clr_p12", SEL_P1, 1);
        expectOut("pre_clr_r31", SEL_RD2, 32'hFFFFFFFF);
        ClearReq = 1'b1;
        expectOut("clr_req_busy", SEL_BUSY, 0);
        tick();
        ClearReq = 1'b0;

        // Sweep: Busy for exactly 32 cycles; writes, reserves, ClearReq dropped.
        for (int k = 0; k < 32; k++) begin
            expectOut("sweep_busy", SEL_BUSY, 1);
            RegWrite = (k == 5);
            WriteRegister = 3; WriteData = 32'h1;
            Reserve = (k == 15); ReserveReg = 4;
            ClearReq = (k == 20);
            if (k == 10) begin
                ReadRegister1 = 20; ReadRegister2 = 2;
                expectOut("sweep_mix_uncleared", SEL_RD1, 32'hFFFFFFFF);
                expectOut("sweep_mix_cleared", SEL_RD2, 0);
            end
            tick();
        end
        RegWrite = 1'b0; Reserve = 1'b0; ClearReq = 1'b0;

        // First cycle after the sweep accepts a write.
        expectOut("sweep_done_busy", SEL_BUSY, 0);
        RegWrite = 1'b1; WriteRegister = 6; WriteData = 32'h66; ReadRegister1 = 1;
        tick();
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = AW'(a);
            ReadRegister2 = AW'(a);
            expectOut("post_clr_rd", SEL_RD1, (a == 6) ? 32'h66 : 32'h0);
            expectOut("post_clr_p", SEL_P2, 0);
            tick();
        end

        // Reset in the middle of a sweep.
        RegWrite = 1'b1; WriteRegister = 20; WriteData = 32'h20;
        tick();
        RegWrite = 1'b0; Reserve = 1'b1; ReserveReg = 25;
        tick();
        Reserve = 1'b0; ReadRegister1 = 20; ReadRegister2 = 25;
        expectOut("pre_rst_r20", SEL_RD1, 32'h20);
        expectOut("pre_rst_p25", SEL_P2, 1);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        repeat (10) tick();
        expectOut("mid_sweep_busy", SEL_BUSY, 1);
        expectOut("mid_sweep_r20", SEL_RD1, 32'h20);
        tick();
        Rst_n = 1'b0;
        expectOut("rst_busy", SEL_BUSY, 0);
        expectOut("rst_r20", SEL_RD1, 0);
        expectOut("rst_p25", SEL_P2, 0);
        tick();
        Rst_n = 1'b1;
        RegWrite = 1'b1; WriteRegister = 11; WriteData = 32'hBB; ReadRegister1 = 1;
        expectOut("rel_busy", SEL_BUSY, 0);
        tick();
        RegWrite = 1'b0;
        ReadRegister1 = 11; ReadRegister2 = 6;
        expectOut("rel_wr11", SEL_RD1, 32'hBB);
        expectOut("rel_r6_cleared", SEL_RD2, 0);
        tick();
        ReadRegister1 = 5; ReadRegister2 = 31;
        expectOut("rel_r5_cleared", SEL_RD1, 0);
        expectOut("rel_r31_cleared", SEL_RD2, 0);
        tick();

        // Let the monitor drain; leftover entries count as failures.
        repeat (2) @(negedge Clk);
        #1;
        checkCount++;
        if (scoreboard.size() != 0) begin
            errorCount++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised general-purpose register file for the single-cycle/pipelined MIPS datapath, the successor to the fixed 32x32 register file. It has configurable data width and depth, a hardwired-zero register 0, and a per-register pending scoreboard for pipeline hazard detection. A runtime clear sequencer zeroes the whole array without a chip reset. It sits between decode (read ports, scoreboard reserve) and writeback (write port).

## Interface
- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and reserves

- Clk  input  1  clock; all state updates on posedge
- Rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- ReadRegister1, ReadRegister2  input  ADDR_WIDTH  read addresses
- ReadData1, ReadData2  output  DATA_WIDTH  combinational read data
- WriteRegister  input  ADDR_WIDTH  write address
- WriteData  input  DATA_WIDTH  write data
- RegWrite  input  1  write enable
- Reserve  input  1  mark ReserveReg as pending (producer issued)
- ReserveReg  input  ADDR_WIDTH  register to reserve
- Pending1, Pending2  output  1  scoreboard bit for ReadRegister1/2
- ClearReq  input  1  one-cycle pulse; start the zeroing sweep
- Busy  output  1  sweep in progress

## Operation
- Reset (Rst_n=0, async): all registers = 0, all pending bits = 0, FSM = IDLE, sweep counter = 0, Busy = 0. ReadData/Pending outputs = 0.
- Write: at posedge, if RegWrite and FSM=IDLE, Reg[WriteRegister] <= WriteData. A write to register 0 is dropped when ZERO_REG=1.
- Read: ReadDataN = Reg[ReadRegisterN]. Forced to 0 for address 0 when ZERO_REG=1.
- Scoreboard:
  - Reserve sets pend[ReserveReg].
  - A RegWrite to a register clears its pending bit.
  - Same-cycle Reserve and RegWrite to the same register: set wins.
  - Reserve of reg 0 is ignored when ZERO_REG=1.
  - PendingN = pend[ReadRegisterN].
- FSM IDLE -> SWEEP on ClearReq while IDLE.
  - In SWEEP, each cycle Reg[cnt] <= 0 and pend[cnt] <= 0, then cnt++.
  - SWEEP -> IDLE after the cycle with cnt = DEPTH-1; cnt then returns to 0.
- During SWEEP:
  - Busy = 1.
  - RegWrite and Reserve are ignored (dropped, not queued).
  - ClearReq is ignored.
  - Reads return current array contents, so cleared and uncleared entries may be mixed.
- Rst_n asserted mid-sweep: immediate full reset, FSM = IDLE.

## Timing
- Read latency 0 (combinational). Write, reserve and clear effects are visible after the posedge.
- Write and read of the same address in the same cycle: see Configuration.
- Sweep duration is exactly DEPTH cycles.
  - Busy rises in the cycle after the ClearReq posedge.
  - Busy falls after DEPTH posedges in SWEEP.
  - The first cycle after that is the first cycle in which a write is accepted.
- Counter width ADDR_WIDTH; it wraps naturally from DEPTH-1 to 0.

## Configuration
- REGFILE_BYPASS_EN defined (write-first forwarding): if RegWrite, FSM=IDLE and WriteRegister==ReadRegisterN (nonzero, or any address when ZERO_REG=0):
  - ReadDataN = WriteData in the same cycle.
  - PendingN = 0 in the same cycle.
- REGFILE_BYPASS_EN undefined (read-before-write): ReadDataN and PendingN show the pre-write state until the next posedge.

## Test plan
- Reset then read all addresses -> every ReadData = 0 and Pending = 0; write 0xDEADBEEF to reg 5 then read reg 5 -> 0xDEADBEEF.
- With ZERO_REG=1, write 0x12345678 to reg 0 and Reserve reg 0 -> ReadData1 = 0, Pending1 = 0.
- Same cycle: RegWrite reg 7 = 0xA5A5A5A5 with ReadRegister1 = 7.
  - With REGFILE_BYPASS_EN: ReadData1 = 0xA5A5A5A5 that cycle.
  - Without: ReadData1 = old value (0) that cycle and 0xA5A5A5A5 next cycle.
- Scoreboard sequence:
  - Reserve reg 9 -> Pending2 = 1 next cycle (ReadRegister2 = 9).
  - Same-cycle Reserve and RegWrite reg 9 -> Pending2 stays 1.
  - Later RegWrite reg 9 alone -> Pending2 = 0.
- Fill regs 1..31 with 0xFFFFFFFF, pulse ClearReq, and RegWrite reg 3 = 0x1 during the sweep.
  - Busy is high for exactly 32 cycles.
  - All regs read 0 afterwards and the reg 3 write is dropped.
- Assert Rst_n low at sweep cycle 10 -> Busy = 0 immediately; all regs 0; a write in the first cycle after release is accepted.
